// File: rtl/unit_spawn_scheduler_pkg.sv
// Shared types and constants for the player unit spawn scheduler:
// FSM states, unit type codes, unit costs and the "no position" marker.
package unit_spawn_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT     = 2'd2,
        ST_COOLDOWN = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        UT_NONE = 2'b00,
        UT_T1   = 2'b01,
        UT_T2   = 2'b10,
        UT_T3   = 2'b11
    } unit_type_e;

    localparam logic [7:0] COST_T1  = 8'd10;
    localparam logic [7:0] COST_T2  = 8'd20;
    localparam logic [7:0] COST_T3  = 8'd50;
    localparam logic [8:0] POS_NONE = 9'h1FF;

    function automatic logic [7:0] unit_cost(input unit_type_e t);
        case (t)
            UT_T1:   unit_cost = COST_T1;
            UT_T2:   unit_cost = COST_T2;
            UT_T3:   unit_cost = COST_T3;
            default: unit_cost = 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/unit_spawn_scheduler_free_slot_finder.sv
// Combinational lowest-index-set priority encoder over the dead flags:
// one-hot pick of the first free slot plus a valid bit.
module free_slot_finder #(
    parameter int N_UNITS = 8
) (
    input  logic [N_UNITS-1:0] unit_dead,
    output logic [N_UNITS-1:0] slot_onehot,
    output logic               slot_valid
);

    assign slot_valid = |unit_dead;

    generate
        for (genvar gi = 0; gi < N_UNITS; gi++) begin : g_pick
            if (gi == 0) begin : g_first
                assign slot_onehot[gi] = unit_dead[gi];
            end else begin : g_rest
                assign slot_onehot[gi] = unit_dead[gi] & ~(|unit_dead[gi-1:0]);
            end
        end
    endgenerate

endmodule

// File: rtl/unit_spawn_scheduler.sv
// Player unit slot controller: spawn arbitration against gold and cooldown,
// periodic game tick generation and player front position reduction.
module unit_spawn_scheduler
    import unit_spawn_scheduler_pkg::*;
#(
    parameter int N_UNITS        = 8,
    parameter int TICK_DIV       = 16,
    parameter int COOLDOWN_TICKS = 4,
    parameter int GOLD_INIT      = 50,
    parameter int GOLD_MAX       = 255,
    parameter int GOLD_INC       = 1,
    parameter int SPAWN_TIMEOUT  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   leftBtn,
    input  logic                   rightBtn,
    input  logic                   downBtn,
    input  logic [N_UNITS-1:0]     unitDead,
    input  logic [9*N_UNITS-1:0]   unitPosition,
    output logic [N_UNITS-1:0]     canSpawn,
    output logic                   leftSCEN,
    output logic                   rightSCEN,
    output logic                   downSCEN,
    output logic                   moveSCEN,
    output logic                   damageSCEN,
    output logic [7:0]             gold,
    output logic [8:0]             playerFront,
    output logic                   busy,
    output logic                   reject,
    output logic                   spawnFault
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    state_e               state_q, state_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [7:0]           cd_cnt_q, cd_cnt_d;
    logic [7:0]           wait_cnt_q, wait_cnt_d;
    logic [N_UNITS-1:0]   slot_q, slot_d;
    logic [N_UNITS-1:0]   can_spawn_q, can_spawn_d;
    logic                 left_scen_q, left_scen_d;
    logic                 right_scen_q, right_scen_d;
    logic                 down_scen_q, down_scen_d;
    logic                 move_q, move_d;
    logic                 damage_q, damage_d;
    logic [7:0]           gold_q, gold_d;
    logic [8:0]           front_q, front_d;
    logic                 busy_q, busy_d;
    logic                 reject_q, reject_d;
    logic                 fault_q, fault_d;

    logic [N_UNITS-1:0]   free_onehot;
    logic                 free_valid;
    logic                 tick_hit;
    logic                 debit;
    unit_type_e           req_type;
    logic [7:0]           req_cost;
    logic [9:0]           gold_sum;

    free_slot_finder #(.N_UNITS(N_UNITS)) u_free_slot_finder (
        .unit_dead   (unitDead),
        .slot_onehot (free_onehot),
        .slot_valid  (free_valid)
    );

    always_comb begin
        state_d      = state_q;
        cd_cnt_d     = cd_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        slot_d       = slot_q;
        can_spawn_d  = '0;
        left_scen_d  = 1'b0;
        right_scen_d = 1'b0;
        down_scen_d  = 1'b0;
        reject_d     = 1'b0;
        fault_d      = 1'b0;
        debit        = 1'b0;

        tick_hit   = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick_hit ? '0 : tick_cnt_q + 1'b1;
        move_d     = tick_hit;
        damage_d   = move_q;

        if (leftBtn)       req_type = UT_T1;
        else if (rightBtn) req_type = UT_T2;
        else if (downBtn)  req_type = UT_T3;
        else               req_type = UT_NONE;
        req_cost = unit_cost(req_type);

        case (state_q)
            ST_IDLE: begin
                if (req_type != UT_NONE) begin
                    if (gold_q >= req_cost && free_valid) begin
                        state_d      = ST_ISSUE;
                        slot_d       = free_onehot;
                        can_spawn_d  = free_onehot;
                        left_scen_d  = (req_type == UT_T1);
                        right_scen_d = (req_type == UT_T2);
                        down_scen_d  = (req_type == UT_T3);
                        debit        = 1'b1;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                // The ISSUE cycle itself counts toward the spawn timeout.
                state_d    = ST_WAIT;
                wait_cnt_d = 8'd1;
            end
            ST_WAIT: begin
                if ((unitDead & slot_q) == '0) begin
                    state_d  = ST_COOLDOWN;
                    cd_cnt_d = 8'(COOLDOWN_TICKS);
                end else if (wait_cnt_q >= 8'(SPAWN_TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                    fault_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            ST_COOLDOWN: begin
                if (tick_hit) begin
                    if (cd_cnt_q <= 8'd1) begin
                        cd_cnt_d = 8'd0;
                        state_d  = ST_IDLE;
                    end else begin
                        cd_cnt_d = cd_cnt_q - 8'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Debit only happens when gold_q >= cost, so the sum never underflows.
        gold_sum = {2'b00, gold_q}
                 + (tick_hit ? 10'(GOLD_INC) : 10'd0)
                 - (debit ? {2'b00, req_cost} : 10'd0);
        gold_d = (gold_sum > 10'(GOLD_MAX)) ? 8'(GOLD_MAX) : gold_sum[7:0];

        busy_d = (state_d != ST_IDLE);
    end

    always_comb begin
        front_d = POS_NONE;
        for (int i = 0; i < N_UNITS; i++) begin
            if (!unitDead[i] && (unitPosition[9*i +: 9] < front_d)) begin
                front_d = unitPosition[9*i +: 9];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            tick_cnt_q   <= '0;
            cd_cnt_q     <= '0;
            wait_cnt_q   <= '0;
            slot_q       <= '0;
            can_spawn_q  <= '0;
            left_scen_q  <= 1'b0;
            right_scen_q <= 1'b0;
            down_scen_q  <= 1'b0;
            move_q       <= 1'b0;
            damage_q     <= 1'b0;
            gold_q       <= 8'(GOLD_INIT);
            front_q      <= POS_NONE;
            busy_q       <= 1'b0;
            reject_q     <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            cd_cnt_q     <= cd_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            slot_q       <= slot_d;
            can_spawn_q  <= can_spawn_d;
            left_scen_q  <= left_scen_d;
            right_scen_q <= right_scen_d;
            down_scen_q  <= down_scen_d;
            move_q       <= move_d;
            damage_q     <= damage_d;
            gold_q       <= gold_d;
            front_q      <= front_d;
            busy_q       <= busy_d;
            reject_q     <= reject_d;
            fault_q      <= fault_d;
        end
    end

    assign canSpawn    = can_spawn_q;
    assign leftSCEN    = left_scen_q;
    assign rightSCEN   = right_scen_q;
    assign downSCEN    = down_scen_q;
    assign moveSCEN    = move_q;
    assign damageSCEN  = damage_q;
    assign gold        = gold_q;
    assign playerFront = front_q;
    assign busy        = busy_q;
    assign reject      = reject_q;
    assign spawnFault  = fault_q;

endmodule
